line_transfer_engine: RTL

- Memory-side stage directly downstream of the cache controller's memory port.
- Consumes the controller's fetch request and address, and its write-back request, address and line data.
- Returns the fetched line and the write-back acknowledge.
- Moves each BLOCK_SIZE-byte line over a narrower MEM_WIDTH main-memory bus as a sequence of single-beat valid/ready transfers.

---
 rtl/line_transfer_engine.sv | 131 +++++++++++++
 1 files changed

// File: rtl/line_transfer_engine.sv
// Moves one cache line between the cache controller and a narrower main-memory bus.
// Write-backs take priority over fills; each line travels as BEATS single-beat valid/ready transfers.
module line_transfer_engine #(
  parameter int BLOCK_SIZE    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int MEM_WIDTH     = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       fetchReq,
  input  logic [ADDRESS_WIDTH-1:0]   fetchAddress,
  output logic [8*BLOCK_SIZE-1:0]    fetchedData,
  output logic                       fetchDone,
  input  logic                       writeBackReq,
  input  logic [ADDRESS_WIDTH-1:0]   writeBackAddress,
  input  logic [8*BLOCK_SIZE-1:0]    writeBackData,
  output logic                       writeBackAck,
  output logic                       busy,
  output logic                       memValid,
  output logic                       memWe,
  output logic [ADDRESS_WIDTH-1:0]   memAddr,
  output logic [MEM_WIDTH-1:0]       memWData,
  input  logic                       memReady,
  input  logic [MEM_WIDTH-1:0]       memRData
);

  localparam int LINE_BITS  = 8 * BLOCK_SIZE;
  localparam int BEATS      = LINE_BITS / MEM_WIDTH;
  localparam int BEAT_BYTES = MEM_WIDTH / 8;
  localparam int BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [BEAT_W-1:0]        LAST_BEAT  = BEAT_W'(BEATS - 1);
  localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK = ~ADDRESS_WIDTH'(BLOCK_SIZE - 1);
  localparam logic [ADDRESS_WIDTH-1:0] BEAT_STEP  = ADDRESS_WIDTH'(BEAT_BYTES);

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} stateT;
  typedef enum logic {KIND_FETCH, KIND_WB} kindT;

  stateT                    state;
  stateT                    nextState;
  kindT                     kind;
  logic [BEAT_W-1:0]        beat;
  logic [ADDRESS_WIDTH-1:0] base;
  logic [LINE_BITS-1:0]     lineBuf;
  logic                     transferring;
  logic                     lastBeatAccepted;

  assign transferring     = (state == WRITE) || (state == READ);
  assign lastBeatAccepted = transferring && memReady && (beat == LAST_BEAT);

  // NOTE: registers update with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  // NOTE: every combinational output gets a default first, otherwise a missed branch infers a latch.
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (writeBackReq)  nextState = WRITE;
        else if (fetchReq) nextState = READ;
      end
      WRITE, READ: begin
        if (lastBeatAccepted) nextState = RESP;
      end
      RESP:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Transfer bookkeeping; the beat counter wraps to 0 as the last beat is accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat        <= '0;
      base        <= '0;
      kind        <= KIND_FETCH;
      fetchedData <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (writeBackReq) begin
            base <= writeBackAddress & ALIGN_MASK;
            kind <= KIND_WB;
          end else if (fetchReq) begin
            base <= fetchAddress & ALIGN_MASK;
            kind <= KIND_FETCH;
          end
        end
        WRITE, READ: begin
          if (memReady) begin
            if (state == READ) fetchedData[beat*MEM_WIDTH +: MEM_WIDTH] <= memRData;
            beat <= (beat == LAST_BEAT) ? '0 : beat + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: the line buffer is a wide data store with no reset; memWData is gated outside WRITE instead.
  always_ff @(posedge clk) begin
    if (state == IDLE && writeBackReq) lineBuf <= writeBackData;
  end

  // Bus outputs decode registered state only, so they cannot move while a beat is stalled.
  always_comb begin
    memValid     = 1'b0;
    memWe        = 1'b0;
    memWData     = '0;
    fetchDone    = 1'b0;
    writeBackAck = 1'b0;
    busy         = (state != IDLE);
    memAddr      = base + ADDRESS_WIDTH'(beat) * BEAT_STEP;
    case (state)
      WRITE: begin
        memValid = 1'b1;
        memWe    = 1'b1;
        memWData = lineBuf[beat*MEM_WIDTH +: MEM_WIDTH];
      end
      READ: memValid = 1'b1;
      RESP: begin
        if (kind == KIND_WB) writeBackAck = 1'b1;
        else                 fetchDone    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
